or1200_wb_arbiter: RTL

//  Schedules the two per-cycle writeback results (slot 1 older, slot 2 younger) of the dual-issue pipeline onto the register-file write ports.
//  - Merges same-cycle WAW pairs.
//  - Buffers results in an in-order queue when write ports are short, and raises wb_stall when the queue cannot take another pair.
//  - Flags reads of registers whose writes are still queued, so decode can hold.
//  - Sits between or1200_wbmux outputs and or1200_rf write ports.

---
 rtl/or1200_wb_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/or1200_wb_arbiter.sv
// or1200_wb_arbiter: in-order writeback queue that merges same-cycle WAW pairs and
// feeds one or two register-file write ports, with stall and read-hazard flags.
module or1200_wb_arbiter #(
    parameter int RF_WR_PORTS = 2,
    parameter int QDEPTH      = 4,
    parameter int QAW         = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wb_freeze,
    input  logic           wb_valid,
    input  logic [4:0]     wb_addr,
    input  logic [31:0]    wb_data,
    input  logic           wb_valid2,
    input  logic [4:0]     wb_addr2,
    input  logic [31:0]    wb_data2,
    input  logic [4:0]     rd_addr_a,
    input  logic [4:0]     rd_addr_b,
    output logic           rf_we,
    output logic [4:0]     rf_addrw,
    output logic [31:0]    rf_dataw,
    output logic           rf_we2,
    output logic [4:0]     rf_addrw2,
    output logic [31:0]    rf_dataw2,
    output logic           wb_stall,
    output logic           rd_hit_a,
    output logic           rd_hit_b,
    output logic [QAW:0]   q_count
);
    localparam logic [QAW:0] TWO = (QAW+1)'(2);

    logic [4:0]     addr_q [QDEPTH];
    logic [31:0]    data_q [QDEPTH];
    logic [QAW-1:0] head_q, tail_q, head_d, tail_d, h1, wr2;
    logic [QAW:0]   count_q, count_d;
    logic [QAW+1:0] room;
    logic [1:0]     pops, pushes;
    logic           we1_raw, we2_raw, acc1, acc2, push1;

    assign h1      = head_q + 1'b1;
    assign we1_raw = count_q != '0;
    assign we2_raw = (RF_WR_PORTS == 2) && (count_q >= TWO);
    assign pops    = {1'b0, we1_raw} + {1'b0, we2_raw};
    // Room counts slots freed by this cycle's pops, since pop is applied before push
    assign room     = (QAW+2)'(QDEPTH) - (QAW+2)'(count_q) + (QAW+2)'(pops);
    assign wb_stall = room < (QAW+2)'(2);
    assign acc1     = wb_valid & ~wb_freeze & ~wb_stall;
    assign acc2     = wb_valid2 & ~wb_freeze & ~wb_stall;
    assign push1    = acc1 & ~(acc2 && wb_addr == wb_addr2);
    assign pushes   = {1'b0, push1} + {1'b0, acc2};
    assign wr2      = push1 ? tail_q + 1'b1 : tail_q;
    assign head_d   = head_q + QAW'(pops);
    assign tail_d   = tail_q + QAW'(pushes);
    assign count_d  = count_q + (QAW+1)'(pushes) - (QAW+1)'(pops);

    // Older head entry is suppressed when the younger one hits the same register
    assign rf_we     = we1_raw & ~(we2_raw && addr_q[head_q] == addr_q[h1]);
    assign rf_addrw  = we1_raw ? addr_q[head_q] : '0;
    assign rf_dataw  = we1_raw ? data_q[head_q] : '0;
    assign rf_we2    = we2_raw;
    assign rf_addrw2 = we2_raw ? addr_q[h1] : '0;
    assign rf_dataw2 = we2_raw ? data_q[h1] : '0;
    assign q_count   = count_q;

    always_comb begin
        rd_hit_a = 1'b0;
        rd_hit_b = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((QAW+1)'(i) < count_q) begin
                rd_hit_a = rd_hit_a | (addr_q[head_q + QAW'(i)] == rd_addr_a);
                rd_hit_b = rd_hit_b | (addr_q[head_q + QAW'(i)] == rd_addr_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push1) begin
            addr_q[tail_q] <= wb_addr;
            data_q[tail_q] <= wb_data;
        end
        if (!rst && acc2) begin
            addr_q[wr2] <= wb_addr2;
            data_q[wr2] <= wb_data2;
        end
    end
endmodule
